// File: rtl/pipelined_sum_chain.sv
// Flow-controlled multi-operand adder: one add per stage, NUM_OPS-1 stages, global stall,
// optional unsigned saturation, per-result overflow flag and a sticky overflow indicator.
module pipelined_sum_chain #(
   parameter int WIDTH    = 16,
   parameter int NUM_OPS  = 3,
   parameter int SAT_MODE = 0
) (
   input  logic                     clock,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_OPS*WIDTH-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_ovf,
   output logic                     ovf_sticky,
   input  logic                     clr_sticky
);

   localparam int NUM_STAGES = NUM_OPS - 1;

   logic advance;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
      // operands still waiting to be added after this stage
      localparam int REM = NUM_OPS - 2 - s;

      logic             vld_q;
      logic             ovf_q;
      logic [WIDTH-1:0] sum_q;
      logic             vld_in;
      logic             ovf_in;
      logic [WIDTH-1:0] op_a;
      logic [WIDTH-1:0] op_b;
      logic [WIDTH:0]   raw;
      logic [WIDTH-1:0] sum_d;

      if (s == 0) begin : g_src
         assign vld_in = in_valid;
         assign ovf_in = 1'b0;
         assign op_a   = in_data[0 +: WIDTH];
         assign op_b   = in_data[WIDTH +: WIDTH];
      end else begin : g_src
         assign vld_in = g_stage[s-1].vld_q;
         assign ovf_in = g_stage[s-1].ovf_q;
         assign op_a   = g_stage[s-1].sum_q;
         assign op_b   = g_stage[s-1].g_rem.rem_q[WIDTH-1:0];
      end

      assign raw   = {1'b0, op_a} + {1'b0, op_b};
      assign sum_d = ((SAT_MODE != 0) && raw[WIDTH]) ? '1 : raw[WIDTH-1:0];

      // data registers load only with a valid slot so out_data stays 0 until the first result
      always_ff @(posedge clock or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
            sum_q <= '0;
         end else if (advance) begin
            vld_q <= vld_in;
            if (vld_in) begin
               sum_q <= sum_d;
               ovf_q <= ovf_in | raw[WIDTH];
            end
         end
      end

      if (REM > 0) begin : g_rem
         logic [REM*WIDTH-1:0] rem_q;
         logic [REM*WIDTH-1:0] rem_d;

         if (s == 0) begin : g_rsrc
            assign rem_d = in_data[NUM_OPS*WIDTH-1 -: REM*WIDTH];
         end else begin : g_rsrc
            assign rem_d = g_stage[s-1].g_rem.rem_q[(REM+1)*WIDTH-1 -: REM*WIDTH];
         end

         always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
               rem_q <= '0;
            end else if (advance && vld_in) begin
               rem_q <= rem_d;
            end
         end
      end
   end

   assign out_valid = g_stage[NUM_STAGES-1].vld_q;
   assign out_data  = g_stage[NUM_STAGES-1].sum_q;
   assign out_ovf   = g_stage[NUM_STAGES-1].ovf_q;

   // a consumed overflowing result beats a simultaneous clear
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
      end else if (out_valid && out_ready && out_ovf) begin
         ovf_sticky <= 1'b1;
      end else if (clr_sticky) begin
         ovf_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipelined_sum_chain.sv
// Directed bench: 16-bit/3-operand wrap and saturate instances plus an 8-bit/5-operand instance.
module tb_pipelined_sum_chain;

   logic clock = 1'b0;
   logic rst_n;

   always #5 clock = ~clock;

   logic        in_valid, out_ready, clr_sticky;
   logic [47:0] in_data;
   logic        in_ready_w, out_valid_w, out_ovf_w, sticky_w;
   logic [15:0] out_data_w;
   logic        in_ready_s, out_valid_s, out_ovf_s, sticky_s;
   logic [15:0] out_data_s;

   logic        in_valid8, out_ready8, clr8;
   logic [39:0] in_data8;
   logic        in_ready8, out_valid8, out_ovf8, sticky8;
   logic [7:0]  out_data8;

   pipelined_sum_chain #(.WIDTH(16), .NUM_OPS(3), .SAT_MODE(0)) dut_wrap (
      .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_data(in_data), .out_valid(out_valid_w), .out_ready(out_ready),
      .out_data(out_data_w), .out_ovf(out_ovf_w), .ovf_sticky(sticky_w),
      .clr_sticky(clr_sticky));

   pipelined_sum_chain #(.WIDTH(16), .NUM_OPS(3), .SAT_MODE(1)) dut_sat (
      .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
      .out_data(out_data_s), .out_ovf(out_ovf_s), .ovf_sticky(sticky_s),
      .clr_sticky(clr_sticky));

   pipelined_sum_chain #(.WIDTH(8), .NUM_OPS(5), .SAT_MODE(0)) dut_w8 (
      .clock(clock), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready8),
      .out_data(out_data8), .out_ovf(out_ovf8), .ovf_sticky(sticky8),
      .clr_sticky(clr8));

   typedef struct {
      logic [47:0] data;
      logic [15:0] exp_wrap;
      logic [15:0] exp_sat;
      logic        ovf;
   } vec3_t;

   typedef struct {
      logic [39:0] data;
      logic [7:0]  exp;
      logic        ovf;
   } vec5_t;

   vec3_t       v3 [8];
   vec5_t       v5 [5];
   int          total = 0;
   int          bad = 0;
   logic        exp_sticky;
   logic [15:0] got [$];
   int          first_c, last_c, sent, rcv, stall_left;
   logic [15:0] held;
   logic        accepted, seen_valid;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // operands packed {op2, op1, op0}
      v3[0] = '{48'h0003_0002_0001, 16'h0006, 16'h0006, 1'b0};
      v3[1] = '{48'h0001_0002_FFFF, 16'h0002, 16'hFFFF, 1'b1};
      v3[2] = '{48'h0000_8000_8000, 16'h0000, 16'hFFFF, 1'b1};
      v3[3] = '{48'h0000_0001_FFFE, 16'hFFFF, 16'hFFFF, 1'b0};
      v3[4] = '{48'h0000_0000_0000, 16'h0000, 16'h0000, 1'b0};
      v3[5] = '{48'h0001_1111_1234, 16'h2346, 16'h2346, 1'b0};
      v3[6] = '{48'hFFFF_0000_0001, 16'h0000, 16'hFFFF, 1'b1};
      v3[7] = '{48'h0002_7FFF_7FFF, 16'h0000, 16'hFFFF, 1'b1};
      v5[0] = '{40'h05_04_03_02_01, 8'h0F, 1'b0};
      v5[1] = '{40'h00_00_00_01_FF, 8'h00, 1'b1};
      v5[2] = '{40'h08_10_20_40_80, 8'hF8, 1'b0};
      v5[3] = '{40'hC8_C8_C8_C8_C8, 8'hE8, 1'b1};
      v5[4] = '{40'hF0_40_30_20_10, 8'h90, 1'b1};

      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0; in_data = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; clr8 = 1'b0; in_data8 = '0;

      for (int i = 0; i < 4; i++) begin
         in_valid   = 1'($urandom());
         out_ready  = 1'($urandom());
         clr_sticky = 1'($urandom());
         in_data    = {16'($urandom()), 32'($urandom())};
         in_valid8  = 1'($urandom());
         out_ready8 = 1'($urandom());
         in_data8   = {8'($urandom()), 32'($urandom())};
         tick();
         chk("rst out_valid", out_valid_w, 0);
         chk("rst out_data", out_data_w, 0);
         chk("rst out_ovf", out_ovf_w, 0);
         chk("rst sticky", sticky_w, 0);
         chk("rst in_ready", in_ready_w, 1);
         chk("rst sat out_valid", out_valid_s, 0);
         chk("rst w8 out_data", out_data8, 0);
         chk("rst w8 in_ready", in_ready8, 1);
      end
      rst_n = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0; in_data = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; clr8 = 1'b0; in_data8 = '0;
      tick();

      exp_sticky = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_data = v3[i].data; in_valid = 1'b1;
         #1;
         chk($sformatf("v%0d in_ready", i), in_ready_w, 1);
         tick();
         in_valid = 1'b0;
         chk($sformatf("v%0d early valid", i), out_valid_w, 0);
         tick();
         chk($sformatf("v%0d valid", i), out_valid_w, 1);
         chk($sformatf("v%0d wrap data", i), out_data_w, v3[i].exp_wrap);
         chk($sformatf("v%0d sat data", i), out_data_s, v3[i].exp_sat);
         chk($sformatf("v%0d wrap ovf", i), out_ovf_w, v3[i].ovf);
         chk($sformatf("v%0d sat ovf", i), out_ovf_s, v3[i].ovf);
         tick();
         exp_sticky = exp_sticky | v3[i].ovf;
         chk($sformatf("v%0d wrap sticky", i), sticky_w, exp_sticky);
         chk($sformatf("v%0d sat sticky", i), sticky_s, exp_sticky);
         chk($sformatf("v%0d drained", i), out_valid_w, 0);
      end

      first_c = -1; last_c = -1;
      for (int c = 0; c < 12; c++) begin
         in_valid = (c < 8);
         in_data  = {32'h0, 16'(c + 1)};
         tick();
         if (out_valid_w) begin
            if (first_c < 0) first_c = c;
            last_c = c;
            got.push_back(out_data_w);
         end
      end
      in_valid = 1'b0;
      chk("stream count", got.size(), 8);
      chk("stream first", first_c, 1);
      chk("stream last", last_c, 8);
      for (int i = 0; i < got.size(); i++) chk($sformatf("stream data %0d", i), got[i], i + 1);

      sent = 0; rcv = 0; stall_left = 3; held = '0;
      for (int c = 0; c < 16; c++) begin
         if (out_valid_w && stall_left > 0) begin
            if (stall_left == 3) held = out_data_w;
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
         end
         in_valid = (sent < 4);
         in_data  = {32'h0, 16'(sent + 1)};
         #1;
         if (!out_ready) begin
            chk("stall in_ready", in_ready_w, 0);
            chk("stall hold", out_data_w, held);
         end
         accepted = in_valid && in_ready_w;
         if (out_valid_w && out_ready) begin
            chk($sformatf("order %0d", rcv), out_data_w, rcv + 1);
            rcv++;
         end
         tick();
         if (accepted) sent++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("stall happened", stall_left, 0);
      chk("stall sent", sent, 4);
      chk("stall received", rcv, 4);

      // reset while two transfers sit in the pipe with the consumer stalled
      out_ready = 1'b0; in_valid = 1'b1; in_data = {32'h0, 16'h0010};
      tick();
      in_data = {32'h0, 16'h0020};
      tick();
      in_valid = 1'b0;
      chk("pre-rst valid", out_valid_w, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst valid", out_valid_w, 0);
      chk("async rst data", out_data_w, 0);
      chk("async rst in_ready", in_ready_w, 1);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      seen_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (out_valid_w) seen_valid = 1'b1;
      end
      chk("flushed no output", seen_valid, 0);
      chk("post-rst data zero", out_data_w, 0);
      in_data = {16'h0007, 16'h0006, 16'h0005}; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("post-rst valid", out_valid_w, 1);
      chk("post-rst data", out_data_w, 16'h0012);

      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      in_data = v3[1].data; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("ovf result valid", out_valid_w, 1);
      chk("ovf result flag", out_ovf_w, 1);
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      chk("set beats clear", sticky_w, 1);
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      chk("clear alone", sticky_w, 0);

      // clear asserted on every consume: sticky must end up equal to that result's flag
      for (int i = 0; i < 5; i++) begin
         in_data8 = v5[i].data; in_valid8 = 1'b1;
         tick();
         in_valid8 = 1'b0;
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("w8 v%0d early valid", i), out_valid8, 0);
            tick();
         end
         chk($sformatf("w8 v%0d early valid", i), out_valid8, 0);
         tick();
         chk($sformatf("w8 v%0d valid", i), out_valid8, 1);
         chk($sformatf("w8 v%0d data", i), out_data8, v5[i].exp);
         chk($sformatf("w8 v%0d ovf", i), out_ovf8, v5[i].ovf);
         clr8 = 1'b1;
         tick();
         clr8 = 1'b0;
         chk($sformatf("w8 v%0d sticky", i), sticky8, v5[i].ovf);
         chk($sformatf("w8 v%0d drained", i), out_valid8, 0);
      end
      clr8 = 1'b1;
      tick();
      clr8 = 1'b0;
      chk("w8 clear alone", sticky8, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
